// File: rtl/if_stage_if.sv
// Instruction-memory bus between the fetch stage (master) and instruction memory (slave).
// A transfer completes in any cycle where imem_req and imem_ack are both high.
interface if_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: fetch PC, imem req/ack handshake, one-entry skid buffer and a
// registered IF/ID slot; redirects arriving mid-transaction are parked in S_DROP.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  if_stage_if.master        imem,
  output logic [31:0]       inst,
  output logic [31:0]       pc,
  output logic [31:0]       pc4,
  output logic              valid
);

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {S_REQ, S_DROP, S_FULL} state_t;

  state_t              r_state, w_state_nxt;
  logic                r_req_en;
  logic [DATA_W-1:0]   r_fetch_pc, w_fetch_pc_nxt;
  logic [DATA_W-1:0]   r_pend_pc,  w_pend_pc_nxt;
  logic [DATA_W-1:0]   r_buf_inst, w_buf_inst_nxt;
  logic [DATA_W-1:0]   r_buf_pc,   w_buf_pc_nxt;
  logic [DATA_W-1:0]   r_inst_p1,  w_inst_nxt;
  logic [DATA_W-1:0]   r_pc_p1,    w_pc_nxt;
  logic [DATA_W-1:0]   r_pc4_p1,   w_pc4_nxt;
  logic                r_vld_p1,   w_vld_nxt;

  logic                w_req, w_xfer, w_can_load, w_consume;
  logic [DATA_W-1:0]   w_redirect_tgt;

  // r_req_en keeps imem_req low until the first cycle after reset is released.
  assign w_req          = r_req_en && (r_state != S_FULL);
  assign w_xfer         = w_req && imem.imem_ack;
  assign w_can_load     = !r_vld_p1 || !stall;
  assign w_consume      = r_vld_p1 && !stall;
  assign w_redirect_tgt = {redirect_pc[31:2], 2'b00};

  assign imem.imem_req  = w_req;
  assign imem.imem_addr = r_fetch_pc;

  assign inst  = r_inst_p1;
  assign pc    = r_pc_p1;
  assign pc4   = r_pc4_p1;
  assign valid = r_vld_p1;

  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_pend_pc_nxt  = r_pend_pc;
    w_buf_inst_nxt = r_buf_inst;
    w_buf_pc_nxt   = r_buf_pc;
    w_inst_nxt     = r_inst_p1;
    w_pc_nxt       = r_pc_p1;
    w_pc4_nxt      = r_pc4_p1;
    w_vld_nxt      = r_vld_p1;

    case (r_state)
      S_REQ: begin
        if (redirect) begin
          w_vld_nxt  = 1'b0;
          w_inst_nxt = NOP_INST;
          if (w_xfer || !w_req) begin
            w_fetch_pc_nxt = w_redirect_tgt;
          end else begin
            // Request still outstanding: its address must stay on the bus until acked.
            w_pend_pc_nxt = w_redirect_tgt;
            w_state_nxt   = S_DROP;
          end
        end else if (w_xfer) begin
          w_fetch_pc_nxt = r_fetch_pc + 32'd4;
          if (w_can_load) begin
            w_inst_nxt = imem.imem_rdata;
            w_pc_nxt   = r_fetch_pc;
            w_pc4_nxt  = r_fetch_pc + 32'd4;
            w_vld_nxt  = 1'b1;
          end else begin
            w_buf_inst_nxt = imem.imem_rdata;
            w_buf_pc_nxt   = r_fetch_pc;
            w_state_nxt    = S_FULL;
          end
        end else if (w_consume) begin
          w_vld_nxt = 1'b0;
        end
      end

      S_DROP: begin
        if (w_consume) w_vld_nxt = 1'b0;
        if (redirect) begin
          w_pend_pc_nxt = w_redirect_tgt;
          w_vld_nxt     = 1'b0;
          w_inst_nxt    = NOP_INST;
        end
        if (w_xfer) begin
          w_fetch_pc_nxt = redirect ? w_redirect_tgt : r_pend_pc;
          w_state_nxt    = S_REQ;
        end
      end

      S_FULL: begin
        if (redirect) begin
          w_vld_nxt      = 1'b0;
          w_inst_nxt     = NOP_INST;
          w_fetch_pc_nxt = w_redirect_tgt;
          w_state_nxt    = S_REQ;
        end else if (!stall) begin
          w_inst_nxt  = r_buf_inst;
          w_pc_nxt    = r_buf_pc;
          w_pc4_nxt   = r_buf_pc + 32'd4;
          w_vld_nxt   = 1'b1;
          w_state_nxt = S_REQ;
        end
      end

      default: w_state_nxt = S_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_REQ;
    else       r_state <= w_state_nxt;
  end

  // IF/ID slot boundary (p1)
  always_ff @(posedge clk) begin
    if (reset) begin
      r_req_en   <= 1'b0;
      r_fetch_pc <= RESET_PC;
      r_inst_p1  <= NOP_INST;
      r_pc_p1    <= '0;
      r_pc4_p1   <= '0;
      r_vld_p1   <= 1'b0;
    end else begin
      r_req_en   <= 1'b1;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_inst_p1  <= w_inst_nxt;
      r_pc_p1    <= w_pc_nxt;
      r_pc4_p1   <= w_pc4_nxt;
      r_vld_p1   <= w_vld_nxt;
    end
  end

  always_ff @(posedge clk) begin
    r_pend_pc  <= w_pend_pc_nxt;
    r_buf_inst <= w_buf_inst_nxt;
    r_buf_pc   <= w_buf_pc_nxt;
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: addr-tagged instruction memory with a programmable wait count.
module tb_if_stage;
  logic        clk = 1'b0;
  logic        reset, stall, redirect;
  logic [31:0] redirect_pc;
  logic [31:0] inst, pc, pc4;
  logic        valid;
  logic [3:0]  mem_wait;
  logic [3:0]  wcnt;
  int          checks = 0;
  int          failures = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  if_stage_if bus ();

  if_stage dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem        (bus),
    .inst        (inst),
    .pc          (pc),
    .pc4         (pc4),
    .valid       (valid)
  );

  always #5 clk = ~clk;

  // Memory returns {8'hEE, addr[23:0]} after mem_wait extra cycles; reset by the same reset.
  assign bus.imem_ack   = bus.imem_req && (wcnt == mem_wait);
  assign bus.imem_rdata = {8'hEE, bus.imem_addr[23:0]};

  always_ff @(posedge clk) begin
    if (reset || !bus.imem_req || bus.imem_ack) wcnt <= '0;
    else                                         wcnt <= wcnt + 4'd1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; mem_wait = 4'd0;
    step(); step();
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_inst", inst, NOP);
    check("rst_pc", pc, 32'd0);
    check("rst_pc4", pc4, 32'd0);
    check("rst_req", {31'd0, bus.imem_req}, 32'd0);
    reset = 1'b0;
    step();
    check("first_req", {31'd0, bus.imem_req}, 32'd1);
    check("first_addr", bus.imem_addr, 32'd0);
    check("first_valid", {31'd0, valid}, 32'd0);

    // Zero-wait streaming: one instruction per cycle
    for (int i = 0; i < 4; i++) begin
      step();
      check("stream_valid", {31'd0, valid}, 32'd1);
      check("stream_pc", pc, 32'(i * 4));
      check("stream_pc4", pc4, 32'(i * 4 + 4));
      check("stream_inst", inst, 32'hEE00_0000 | 32'(i * 4));
    end

    // Stall for 3 cycles while the word at 16 lands
    stall = 1'b1;
    step();
    check("stall_req_low", {31'd0, bus.imem_req}, 32'd0);
    check("stall_pc_hold", pc, 32'd12);
    check("stall_inst_hold", inst, 32'hEE00_000C);
    step();
    check("stall_pc_hold2", pc, 32'd12);
    step();
    check("stall_pc_hold3", pc, 32'd12);
    check("stall_req_low3", {31'd0, bus.imem_req}, 32'd0);
    stall = 1'b0;
    step();
    check("release_pc", pc, 32'd16);
    check("release_inst", inst, 32'hEE00_0010);
    check("release_req", {31'd0, bus.imem_req}, 32'd1);
    check("release_addr", bus.imem_addr, 32'd20);
    step();
    check("after_release_pc", pc, 32'd20);

    // Redirect together with stall while valid
    redirect = 1'b1; redirect_pc = 32'h40; stall = 1'b1;
    step();
    check("rs_valid", {31'd0, valid}, 32'd0);
    check("rs_inst", inst, NOP);
    check("rs_addr", bus.imem_addr, 32'h40);
    redirect = 1'b0; stall = 1'b0;
    step();
    check("rs_pc", pc, 32'h40);
    check("rs_valid2", {31'd0, valid}, 32'd1);

    // Wrap-around; low bits of redirect_pc ignored
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    step();
    check("wrap_addr", bus.imem_addr, 32'hFFFF_FFFC);
    check("wrap_valid0", {31'd0, valid}, 32'd0);
    redirect = 1'b0;
    step();
    check("wrap_pc", pc, 32'hFFFF_FFFC);
    check("wrap_pc4", pc4, 32'd0);
    check("wrap_next_addr", bus.imem_addr, 32'd0);
    step();
    check("wrap_follow_pc", pc, 32'd0);

    // 2-cycle wait memory, two redirects during the outstanding request
    mem_wait = 4'd2;
    redirect = 1'b1; redirect_pc = 32'h100;
    step();
    check("drop_addr_hold", bus.imem_addr, 32'd4);
    check("drop_req", {31'd0, bus.imem_req}, 32'd1);
    check("drop_valid", {31'd0, valid}, 32'd0);
    redirect_pc = 32'h200;
    step();
    check("drop_addr_hold2", bus.imem_addr, 32'd4);
    redirect = 1'b0;
    step();
    check("drop_new_addr", bus.imem_addr, 32'h200);
    check("drop_no_deliver", {31'd0, valid}, 32'd0);
    step();
    check("drop_no_deliver2", {31'd0, valid}, 32'd0);
    step();
    check("drop_no_deliver3", {31'd0, valid}, 32'd0);
    step();
    check("drop_pc", pc, 32'h200);
    check("drop_inst", inst, 32'hEE00_0200);
    check("drop_valid1", {31'd0, valid}, 32'd1);

    // Reset while in S_DROP
    redirect = 1'b1; redirect_pc = 32'h300;
    step();
    redirect = 1'b0; reset = 1'b1; mem_wait = 4'd0;
    step();
    check("rst2_valid", {31'd0, valid}, 32'd0);
    check("rst2_inst", inst, NOP);
    check("rst2_pc", pc, 32'd0);
    check("rst2_pc4", pc4, 32'd0);
    check("rst2_req", {31'd0, bus.imem_req}, 32'd0);
    reset = 1'b0;
    step();
    check("rst2_addr", bus.imem_addr, 32'd0);
    check("rst2_req1", {31'd0, bus.imem_req}, 32'd1);
    step();
    check("rst2_pc_first", pc, 32'd0);
    check("rst2_inst_first", inst, 32'hEE00_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the 32I pipeline, directly upstream of the decode stage. Holds the fetch PC, runs a req/ack handshake with instruction memory, and presents `inst`, `pc`, `pc4` plus `valid` in a registered IF/ID slot for decode. Honours decode back-pressure (`stall`) through a one-entry skid buffer. Honours control-flow redirects, including one that arrives while a memory request is outstanding.

## Interface

Parameters:
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `NOP_INST`, default 32'h0000_0013: value driven on `inst` when the slot is empty or after reset (addi x0,x0,0).

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: synchronous, active-high.
- `stall` in 1: decode cannot accept; the slot must hold.
- `redirect` in 1: branch/jump taken; discard wrong-path work.
- `redirect_pc` in 32: new fetch target; bits [1:0] treated as 0.
- `imem_req` out 1: fetch request.
- `imem_addr` out 32: fetch address; stable while `imem_req` is high and unacked.
- `imem_ack` in 1: transaction complete this cycle; may be asserted in the same cycle as `imem_req`.
- `imem_rdata` in 32: instruction word, valid when `imem_ack` is high.
- `inst` out 32: instruction to decode.
- `pc` out 32: address of `inst`.
- `pc4` out 32: `pc` + 4.
- `valid` out 1: slot holds a live instruction.

## Operation

State:
- `fetch_pc`
- FSM state: S_REQ, S_DROP or S_FULL
- `pend_pc` (redirect target held in S_DROP)
- skid buffer (`buf_inst`, `buf_pc`)
- output slot (`inst`, `pc`, `pc4`, `valid`)

Definitions:
- A transfer completes in any cycle with `imem_req` && `imem_ack`.
- Decode consumes the slot in any cycle with `valid` && !`stall`.
- The slot can load when !`valid` || !`stall`.

Reset values: `valid`=0, `inst`=`NOP_INST`, `pc`=0, `pc4`=0, `imem_req`=0, state=S_REQ, `fetch_pc`=`RESET_PC`, buffer empty.

S_REQ (`imem_req`=1, `imem_addr`=`fetch_pc`):
- `redirect` && ack: drop `imem_rdata`; `fetch_pc`←`redirect_pc`; stay in S_REQ.
- `redirect` && !ack: `pend_pc`←`redirect_pc`; go to S_DROP.
- ack, slot can load: slot←{`imem_rdata`, `fetch_pc`, `fetch_pc`+4}; `valid`←1; `fetch_pc`+=4.
- ack, slot blocked: buffer←{`imem_rdata`, `fetch_pc`}; `fetch_pc`+=4; go to S_FULL.
- no ack: if the slot is consumed, `valid`←0.

S_DROP (`imem_req`=1, old address held):
- Further `redirect`: `pend_pc`←`redirect_pc` (latest wins).
- On ack: discard data; `fetch_pc`←`pend_pc`; go to S_REQ.
- No instruction is ever delivered from this state.

S_FULL (`imem_req`=0):
- `redirect`: clear buffer; `fetch_pc`←`redirect_pc`; go to S_REQ.
- else !`stall`: slot←buffer; `valid`←1; go to S_REQ.

Redirect in any state sets `valid`←0 and `inst`←`NOP_INST` in that cycle's update. Redirect has priority over stall and ack.

Arithmetic: all PC adds are 32-bit modulo; 32'hFFFF_FFFC + 4 = 0.

The slot is never overwritten while `valid` && `stall`.

## Timing

- Slot is registered: ack at cycle N gives `valid`=1 at N+1.
- With zero-wait memory (ack in the request cycle) and no stall, throughput is 1 instruction per cycle.
- First `imem_req`=1 in the first cycle after `reset` deasserts.
- Redirect at N in S_REQ with ack, or in S_FULL: `imem_addr`=`redirect_pc` at N+1.
- Redirect in S_DROP or S_REQ without ack: the new address is issued the cycle after the outstanding ack.
- Stall release in S_FULL at cycle N: buffered instruction in the slot at N+1, and `imem_req` reasserted at N+1.
- Reset mid-transaction: the outstanding request is abandoned; instruction memory is reset by the same `reset`.

## Test plan

- Reset, zero-wait memory returning addr-tagged words, no stall -> `valid` from cycle 2; `pc`=0,4,8,… on consecutive cycles; `pc4`=`pc`+4.
- `stall` high for 3 cycles while an ack lands -> slot holds; buffer captures the next word; `imem_req`=0 in S_FULL; on release the next `pc` follows with no loss or duplication.
- Memory with 2-cycle wait; `redirect` to 32'h100 in the first wait cycle -> `imem_addr` held until ack; old word dropped; next request at 32'h100; second redirect to 32'h200 in the same window wins.
- `redirect` and `stall` together with `valid`=1 -> `valid`=0 next cycle; next delivered `pc`=`redirect_pc`.
- `redirect_pc`=32'hFFFF_FFFC -> `pc4`=0; following fetch at 32'h0.
- `reset` asserted in S_DROP -> all outputs return to reset values next cycle; fetch restarts at `RESET_PC`.
